// File: rtl/task_job_arbiter.sv
// Purpose : round-robin arbiter + sequencer sharing one multi-beat job unit between two requesters.
// Latency : grant and first beat one cycle after an IDLE sample; job costs len+2 cycles; all outputs registered.
// Backpress: none from the unit; requests are ignored while busy, and a req held through DONE is re-granted.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   req1_i/req2_i            level requests, sampled only in IDLE
//   op1_i/op2_i, base1_i/..  opcode and base address, captured at grant
//   gnt1_o/gnt2_o            one-cycle grant pulse on the first RUN cycle
//   done1_o/done2_o          one-cycle completion pulse in DONE
//   busy_o                   high in RUN and DONE
//   unit_*_o                 beat framing, opcode, address and beat index to the job unit
//   jobs1_o/jobs2_o          saturating completed-job counters (only with TASK_JOB_ARB_STATS_EN)
//
// Optional feature macro: TASK_JOB_ARB_STATS_EN
module task_job_arbiter #(
    parameter int BASE_W    = 18,
    parameter int CNT_W     = 11,
    parameter int BEAT_UNIT = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req1_i,
    input  logic              req2_i,
    input  logic [1:0]        op1_i,
    input  logic [1:0]        op2_i,
    input  logic [BASE_W-1:0] base1_i,
    input  logic [BASE_W-1:0] base2_i,
    output logic              gnt1_o,
    output logic              gnt2_o,
    output logic              done1_o,
    output logic              done2_o,
    output logic              busy_o,
    output logic              unit_valid_o,
    output logic              unit_start_o,
    output logic              unit_end_o,
    output logic [1:0]        unit_op_o,
    output logic [BASE_W-1:0] unit_addr_o,
    output logic [CNT_W-1:0]  unit_cnt_o
`ifdef TASK_JOB_ARB_STATS_EN
    ,
    output logic [15:0]       jobs1_o,
    output logic [15:0]       jobs2_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Job length in CNT_W-bit arithmetic: (op+1)*BEAT_UNIT.
    function automatic logic [CNT_W-1:0] job_len(input logic [1:0] op);
        return (CNT_W'(op) + CNT_W'(1)) * CNT_W'(BEAT_UNIT);
    endfunction

    state_t              state_q, state_d;
    logic                last2_q, last2_d;   // 1: requester 2 was granted last
    logic                sel2_q,  sel2_d;    // 1: current job belongs to requester 2
    logic [1:0]          op_q,    op_d;
    logic [BASE_W-1:0]   base_q,  base_d;
    logic [CNT_W-1:0]    len_q,   len_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BASE_W-1:0]   addr_q,  addr_d;
    logic                gnt1_q, gnt1_d, gnt2_q, gnt2_d;
    logic                done1_q, done1_d, done2_q, done2_d;
    logic                busy_q, busy_d, valid_q, valid_d;
    logic                start_q, start_d, end_q, end_d;

    logic                grant2;
    logic [1:0]          op_sel;
    logic [BASE_W-1:0]   base_sel;

    always_comb begin
        // Tie goes to the requester that was not granted last.
        grant2   = req2_i & (~req1_i | ~last2_q);
        op_sel   = grant2 ? op2_i   : op1_i;
        base_sel = grant2 ? base2_i : base1_i;

        state_d = state_q;
        last2_d = last2_q;
        sel2_d  = sel2_q;
        op_d    = op_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        gnt1_d  = 1'b0;
        gnt2_d  = 1'b0;
        done1_d = 1'b0;
        done2_d = 1'b0;
        busy_d  = busy_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req1_i || req2_i) begin
                    state_d = S_RUN;
                    last2_d = grant2;
                    sel2_d  = grant2;
                    op_d    = op_sel;
                    base_d  = base_sel;
                    len_d   = job_len(op_sel);
                    cnt_d   = '0;
                    addr_d  = base_sel;
                    gnt1_d  = ~grant2;
                    gnt2_d  = grant2;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                    end_d   = (len_d == CNT_W'(1));
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (end_q) begin
                    state_d = S_DONE;
                    done1_d = ~sel2_q;
                    done2_d = sel2_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Carry out of BASE_W is dropped so the address wraps.
                    addr_d  = base_q + BASE_W'(cnt_d);
                    valid_d = 1'b1;
                    end_d   = (cnt_d == len_q - CNT_W'(1));
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            last2_q <= 1'b1;
            sel2_q  <= 1'b0;
            op_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            gnt1_q  <= 1'b0;
            gnt2_q  <= 1'b0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last2_q <= last2_d;
            sel2_q  <= sel2_d;
            op_q    <= op_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            gnt1_q  <= gnt1_d;
            gnt2_q  <= gnt2_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign gnt1_o       = gnt1_q;
    assign gnt2_o       = gnt2_q;
    assign done1_o      = done1_q;
    assign done2_o      = done2_q;
    assign busy_o       = busy_q;
    assign unit_valid_o = valid_q;
    assign unit_start_o = start_q;
    assign unit_end_o   = end_q;
    assign unit_op_o    = op_q;
    assign unit_addr_o  = addr_q;
    assign unit_cnt_o   = cnt_q;

`ifdef TASK_JOB_ARB_STATS_EN
    logic [15:0] jobs1_q, jobs2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            jobs1_q <= '0;
            jobs2_q <= '0;
        end else begin
            if (done1_d && jobs1_q != 16'hFFFF) jobs1_q <= jobs1_q + 16'd1;
            if (done2_d && jobs2_q != 16'hFFFF) jobs2_q <= jobs2_q + 16'd1;
        end
    end

    assign jobs1_o = jobs1_q;
    assign jobs2_o = jobs2_q;
`endif

endmodule
